// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared types and helpers for the time-multiplexed debounce controller.
//   - debounce_state_t : scheduler FSM states
//   - index_width()    : width of a channel index, never less than 1 bit
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // scheduler stopped, outputs held
    PRIME = 2'd1,  // loading debounced levels straight from the synchronizers
    SCAN  = 2'd2   // round-robin debounce service
  } debounce_state_t;

  // A single channel still needs a 1-bit pointer so port widths stay legal.
  function automatic int unsigned index_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_prescaler.sv
// -----------------------------------------------------------------------------
// debounce_prescaler
//   Scan-slot timer shared by every channel. Counts clocks while running and
//   raises o_strobe for one clock each time the count reaches i_prescale.
//
// Ports
//   i_clock     in  1               system clock
//   i_reset_n   in  1               asynchronous active-low reset
//   i_run       in  1               1 = count; 0 = hold the count at zero
//   i_prescale  in  PRESCALE_WIDTH  clocks between strobes minus 1
//   o_strobe    out 1               slot strobe (combinational from the count)
// -----------------------------------------------------------------------------
module debounce_prescaler
  import debounce_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_run,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_strobe
);

  logic [PRESCALE_WIDTH-1:0] count_q;
  logic [PRESCALE_WIDTH-1:0] count_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    count_d  = count_q;
    // Using >= rather than == means a lowered i_prescale strobes on the very
    // next clock instead of waiting for the counter to wrap.
    o_strobe = i_run && (count_q >= i_prescale);
    if (!i_run) begin
      count_d = '0;
    end else if (o_strobe) begin
      count_d = '0;
    end else begin
      count_d = count_q + PRESCALE_WIDTH'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/debounce_scan_scheduler.sv
// -----------------------------------------------------------------------------
// debounce_scan_scheduler
//   Time-multiplexed debounce controller. One prescaler and a round-robin
//   pointer service CHANNEL_COUNT raw inputs, one channel per scan slot, and
//   produce debounced levels plus one-clock rise/fall pulses.
//
// Ports
//   i_clock           in  1                   system clock
//   i_reset_n         in  1                   asynchronous active-low reset
//   i_enable          in  1                   1 = run; 0 = hold outputs, go IDLE
//   i_prescale        in  PRESCALE_WIDTH      clocks between scan slots minus 1
//   i_stable_samples  in  STABLE_COUNT_WIDTH  differing samples needed to flip (0 acts as 1)
//   i_raw             in  CHANNEL_COUNT       asynchronous raw levels
//   o_debounced       out CHANNEL_COUNT       debounced levels
//   o_rise            out CHANNEL_COUNT       one-clock pulse on debounced 0->1
//   o_fall            out CHANNEL_COUNT       one-clock pulse on debounced 1->0
//   o_scan_index      out index_width(CHANNEL_COUNT)  channel of the current slot
//   o_ready           out 1                   1 while scanning
// -----------------------------------------------------------------------------
module debounce_scan_scheduler
  import debounce_pkg::*;
#(
  parameter int CHANNEL_COUNT      = 13,
  parameter int PRESCALE_WIDTH     = 24,
  parameter int STABLE_COUNT_WIDTH = 4,
  localparam int IDX_W             = index_width(CHANNEL_COUNT)
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic                          i_enable,
  input  logic [PRESCALE_WIDTH-1:0]     i_prescale,
  input  logic [STABLE_COUNT_WIDTH-1:0] i_stable_samples,
  input  logic [CHANNEL_COUNT-1:0]      i_raw,
  output logic [CHANNEL_COUNT-1:0]      o_debounced,
  output logic [CHANNEL_COUNT-1:0]      o_rise,
  output logic [CHANNEL_COUNT-1:0]      o_fall,
  output logic [IDX_W-1:0]              o_scan_index,
  output logic                          o_ready
);

  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(CHANNEL_COUNT - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizers (two flops per channel)
  // ---------------------------------------------------------------------------
  logic [CHANNEL_COUNT-1:0] sync_meta_q;
  logic [CHANNEL_COUNT-1:0] sync_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= i_raw;
      sync_q      <= sync_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot timer: only runs in SCAN, and stops on the same clock enable drops
  // ---------------------------------------------------------------------------
  debounce_state_t state_q;
  debounce_state_t state_d;
  logic            slot_strobe;

  debounce_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_run      ((state_q == SCAN) && i_enable),
    .i_prescale (i_prescale),
    .o_strobe   (slot_strobe)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (ptr_q == LAST_INDEX) state_d = SCAN;
        SCAN:    state_d = SCAN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready = (state_q == SCAN);
  end

  // ---------------------------------------------------------------------------
  // Channel datapath: pointer, agreement counters, debounced level, pulses
  // ---------------------------------------------------------------------------
  logic [CHANNEL_COUNT-1:0]      debounced_q, debounced_d;
  logic [CHANNEL_COUNT-1:0]      rise_q, rise_d;
  logic [CHANNEL_COUNT-1:0]      fall_q, fall_d;
  logic [STABLE_COUNT_WIDTH-1:0] cnt_q [CHANNEL_COUNT];
  logic [STABLE_COUNT_WIDTH-1:0] cnt_d [CHANNEL_COUNT];

  logic [STABLE_COUNT_WIDTH-1:0] threshold;
  logic [STABLE_COUNT_WIDTH-1:0] cur_cnt;
  logic [STABLE_COUNT_WIDTH:0]   cnt_plus_one;
  logic [IDX_W-1:0]              ptr_next;

  always_comb begin
    debounced_d  = debounced_q;
    rise_d       = '0;
    fall_d       = '0;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    // A programmed threshold of 0 behaves like 1: flip on the first
    // differing sample.
    threshold    = (i_stable_samples == '0) ? STABLE_COUNT_WIDTH'(1) : i_stable_samples;
    cur_cnt      = cnt_q[ptr_q];
    // One extra bit so the +1 cannot wrap before the compare.
    cnt_plus_one = {1'b0, cur_cnt} + (STABLE_COUNT_WIDTH + 1)'(1);
    ptr_next     = (ptr_q == LAST_INDEX) ? '0 : ptr_q + IDX_W'(1);

    if (!i_enable || (state_q == IDLE)) begin
      // Leaving or sitting in IDLE: levels hold, everything else restarts so
      // that re-enabling always re-primes from a clean slate.
      ptr_d = '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        cnt_d[i] = '0;
      end
    end else if (state_q == PRIME) begin
      // Adopt the current input level silently, one channel per clock.
      debounced_d[ptr_q] = sync_q[ptr_q];
      ptr_d              = ptr_next;
    end else if (slot_strobe) begin
      if (sync_q[ptr_q] == debounced_q[ptr_q]) begin
        // Agreement (including a bounce back) discards any partial count.
        cnt_d[ptr_q] = '0;
      end else if (cnt_plus_one >= {1'b0, threshold}) begin
        debounced_d[ptr_q] = sync_q[ptr_q];
        cnt_d[ptr_q]       = '0;
        if (sync_q[ptr_q]) begin
          rise_d[ptr_q] = 1'b1;
        end else begin
          fall_d[ptr_q] = 1'b1;
        end
      end else if (cur_cnt != '1) begin
        // Saturate rather than wrap.
        cnt_d[ptr_q] = cur_cnt + STABLE_COUNT_WIDTH'(1);
      end
      ptr_d = ptr_next;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_q       <= '0;
      debounced_q <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset here like any other state; a real memory would not be.
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      debounced_q <= debounced_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign o_debounced  = debounced_q;
  assign o_rise       = rise_q;
  assign o_fall       = fall_q;
  assign o_scan_index = ptr_q;

endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// -----------------------------------------------------------------------------
// tb_debounce_scan_scheduler
//   Directed stimulus with a pulse scoreboard. Stimulus pushes the expected
//   pulse (and the debounced level right after it); a monitor pops and checks
//   whenever the DUT emits any rise/fall pulse. Configuration: 4 channels,
//   prescale 2, stable samples 3, except the final edge-config section.
// -----------------------------------------------------------------------------
module tb_debounce_scan_scheduler;

  localparam int N  = 4;
  localparam int PW = 24;
  localparam int SW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_enable;
  logic [PW-1:0] i_prescale;
  logic [SW-1:0] i_stable_samples;
  logic [N-1:0]  i_raw;
  logic [N-1:0]  o_debounced;
  logic [N-1:0]  o_rise;
  logic [N-1:0]  o_fall;
  logic [IW-1:0] o_scan_index;
  logic          o_ready;

  always #5 clk = ~clk;

  debounce_scan_scheduler #(
    .CHANNEL_COUNT      (N),
    .PRESCALE_WIDTH     (PW),
    .STABLE_COUNT_WIDTH (SW)
  ) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_enable         (i_enable),
    .i_prescale       (i_prescale),
    .i_stable_samples (i_stable_samples),
    .i_raw            (i_raw),
    .o_debounced      (o_debounced),
    .o_rise           (o_rise),
    .o_fall           (o_fall),
    .o_scan_index     (o_scan_index),
    .o_ready          (o_ready)
  );

  typedef struct {
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] deb;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_pulse(input logic [N-1:0] rise, input logic [N-1:0] fall,
                              input logic [N-1:0] deb);
    exp_t e;
    e.rise = rise;
    e.fall = fall;
    e.deb  = deb;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) until every expected pulse has been seen.
  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check(name, sb_q.size(), 0);
  endtask

  // Wait (bounded) for the first negedge at which o_scan_index equals idx.
  task automatic wait_index(input string name, input logic [IW-1:0] idx, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_scan_index == idx) begin
        found = 1'b1;
        break;
      end
    end
    check(name, found, 1);
  endtask

  task automatic wait_ready(input string name, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_ready) begin
        found = 1'b1;
        break;
      end
    end
    check(name, found, 1);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((o_rise | o_fall) != '0)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {o_rise, o_fall}, 0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_rise", o_rise, e.rise);
        check("pulse_fall", o_fall, e.fall);
        check("pulse_level", o_debounced, e.deb);
        check("pulse_onehot", $countones(o_rise | o_fall), 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IW-1:0] idx0;

    // ---- Reset / prime --------------------------------------------------
    rst_n            = 1'b0;
    i_enable         = 1'b1;
    i_prescale       = PW'(2);
    i_stable_samples = SW'(3);
    i_raw            = 4'b1010;
    repeat (3) @(negedge clk);
    check("reset_debounced", o_debounced, 4'b0000);
    check("reset_ready", o_ready, 0);
    check("reset_pulses", {o_rise, o_fall}, 0);
    check("reset_index", o_scan_index, 0);
    rst_n = 1'b1;
    wait_ready("prime_ready", 7);
    check("prime_level", o_debounced, 4'b1010);
    check("prime_index", o_scan_index, 0);

    // ---- Clean rising edge on channel 2 ---------------------------------
    @(negedge clk);
    i_raw[2] = 1'b1;
    expect_pulse(4'b0100, 4'b0000, 4'b1110);
    wait_drain("rise2_latency", 38);
    repeat (3) @(negedge clk);
    check("rise2_level_held", o_debounced, 4'b1110);

    // ---- Bounce reject on channel 1 -------------------------------------
    for (int k = 0; k < 20; k++) begin
      repeat (10) @(negedge clk);
      i_raw[1] = ~i_raw[1];
    end
    repeat (40) @(negedge clk);
    check("bounce_level", o_debounced, 4'b1110);

    // ---- Simultaneous flip of all channels, launched as p becomes 2 ------
    wait_index("sync_to_idx1", 2'd1, 20);
    wait_index("sync_to_idx2", 2'd2, 20);
    i_raw = 4'b0001;
    expect_pulse(4'b0000, 4'b0100, 4'b1010);
    expect_pulse(4'b0000, 4'b1000, 4'b0010);
    expect_pulse(4'b0001, 4'b0000, 4'b0011);
    expect_pulse(4'b0000, 4'b0010, 4'b0001);
    wait_drain("simul_drain", 45);
    check("simul_level", o_debounced, 4'b0001);

    // ---- Disable mid-count on channel 0 ---------------------------------
    wait_index("sync_to_idx3", 2'd3, 20);
    wait_index("sync_to_idx0", 2'd0, 20);
    i_raw[0] = 1'b0;
    repeat (20) @(negedge clk);       // two differing samples taken, third pending
    i_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("disable_ready", o_ready, 0);
    check("disable_index", o_scan_index, 0);
    check("disable_level", o_debounced, 4'b0001);
    i_raw[3] = 1'b1;
    repeat (10) @(negedge clk);
    check("disable_hold", o_debounced, 4'b0001);
    i_enable = 1'b1;
    wait_ready("reprime_ready", 7);
    check("reprime_level", o_debounced, 4'b1000);

    // ---- Edge configs: prescale 0, stable samples 0 ---------------------
    @(negedge clk);
    i_prescale       = '0;
    i_stable_samples = '0;
    @(negedge clk);
    idx0 = o_scan_index;
    @(negedge clk);
    check("strobe_every_clock_a", o_scan_index, IW'(idx0 + 2'd1));
    @(negedge clk);
    check("strobe_every_clock_b", o_scan_index, IW'(idx0 + 2'd2));
    i_raw[1] = 1'b1;
    expect_pulse(4'b0010, 4'b0000, 4'b1010);
    wait_drain("fast_rise1", 6);
    @(negedge clk);
    i_raw[3] = 1'b0;
    expect_pulse(4'b0000, 4'b1000, 4'b0010);
    wait_drain("fast_fall3", 6);

    repeat (10) @(negedge clk);
    check("final_level", o_debounced, 4'b0010);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
